regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port among NREQ write-back sources, e.g. ALU, load unit and mult/div.
- Arbitrates valid/ready requests and presents one registered write per cycle on write_enable/write_reg/write_data.
- Keeps a 32-bit pending-write scoreboard so the issue stage can detect RAW hazards against in-flight writes.

---
 rtl/regfile_wb_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Purpose:
//   Shares the register file's single write port among NREQ write-back
//   sources (ALU, load unit, mult/div, ...). Each cycle at most one valid
//   requester is granted. Its destination register and data are captured
//   into a registered output stage, which drives the register file write
//   port in the following cycle. A 32-bit pending-write scoreboard tracks
//   registers reserved by the issue stage whose write has not yet committed,
//   so the issue stage can detect RAW hazards.
//
// Configuration macro:
//   WB_ROUND_ROBIN_EN  defined   -> round-robin arbitration from a pointer
//                      undefined -> fixed priority, lowest index wins
//
// Parameters:
//   NREQ  number of write-back requesters (2..8)
//   RR_W  width of the grant index / round-robin pointer (2**RR_W >= NREQ)
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   req_valid      per-requester write pending
//   req_reg        per-requester destination register, slice [5i+4:5i]
//   req_data       per-requester write data, slice [32i+31:32i]
//   req_ready      one-hot grant (transfer when valid & ready)
//   reserve_valid  issue stage reserves a destination register
//   reserve_reg    register being reserved
//   write_enable   register file write enable (registered)
//   write_reg      register file write address (registered)
//   write_data     register file write data (registered)
//   pending        bit r set = write to register r still in flight

module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int RR_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_reg,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 reserve_valid,
  input  logic [4:0]           reserve_reg,
  output logic                 write_enable,
  output logic [4:0]           write_reg,
  output logic [31:0]          write_data,
  output logic [31:0]          pending
);

  // NREQ in the index width plus one bit, used for the modulo wrap.
  localparam logic [RR_W:0] NREQ_W = (RR_W+1)'(NREQ);

  logic            grant_any;
  logic [RR_W-1:0] grant_idx;
  logic [4:0]      sel_reg;
  logic [31:0]     sel_data;

  logic        write_enable_q, write_enable_d;
  logic [4:0]  write_reg_q,    write_reg_d;
  logic [31:0] write_data_q,   write_data_d;
  logic [31:0] pending_q,      pending_d;

`ifdef WB_ROUND_ROBIN_EN
  logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] valid_rot;
  logic [RR_W:0]   cand_idx;
  logic [RR_W:0]   ptr_next;

  // Rotate the valid vector so the pointer position lands at bit 0, then
  // take the first set bit; the winner's real index is ptr + k, wrapped.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    valid_rot = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && valid_rot[k]) begin
        grant_any = 1'b1;
        cand_idx  = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
        if (cand_idx >= NREQ_W) begin
          cand_idx = cand_idx - NREQ_W;
        end
        grant_idx = cand_idx[RR_W-1:0];
      end
    end
    if (reset) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end

  // After a grant to i the search starts at i+1 (mod NREQ); otherwise hold.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    ptr_next = {1'b0, grant_idx} + (RR_W+1)'(1);
    if (ptr_next == NREQ_W) begin
      ptr_next = '0;
    end
    if (grant_any) begin
      rr_ptr_d = ptr_next[RR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = RR_W'(k);
      end
    end
    if (reset) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end
`endif

  // Decode the winning index into the one-hot ready and mux its payload.
  always_comb begin
    req_ready = '0;
    sel_reg   = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && (grant_idx == RR_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_reg      = req_reg[5*i +: 5];
        sel_data     = req_data[32*i +: 32];
      end
    end
  end

  // A grant to register 0 is accepted but never becomes a write. The
  // address/data registers only load on a real write, so they hold otherwise.
  always_comb begin
    write_enable_d = grant_any && (sel_reg != 5'd0);
    write_reg_d    = write_enable_d ? sel_reg  : write_reg_q;
    write_data_d   = write_enable_d ? sel_data : write_data_q;
  end

  // Clear on the commit edge, then apply the reservation so that a
  // re-reservation of the same register on the same edge wins.
  always_comb begin
    pending_d = pending_q;
    if (write_enable_q) begin
      pending_d[write_reg_q] = 1'b0;
    end
    if (reserve_valid && (reserve_reg != 5'd0)) begin
      pending_d[reserve_reg] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable_q <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      pending_q      <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      pending_q      <= pending_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Purpose:
//   Directed bench for regfile_wb_arbiter (NREQ=3). Stimulus pushes each
//   expected register-file write into a queue; a monitor pops and compares
//   whenever write_enable is seen high. Grants, pending bits and idle
//   behaviour are compared directly against hand-computed values.
//   Contention expectations follow WB_ROUND_ROBIN_EN.

module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_reg;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 reserve_valid;
  logic [4:0]           reserve_reg;
  logic                 write_enable;
  logic [4:0]           write_reg;
  logic [31:0]          write_data;
  logic [31:0]          pending;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [31:0] D0 = 32'h1000_0000;
  localparam logic [31:0] D1 = 32'h1000_0001;
  localparam logic [31:0] D2 = 32'h1000_0002;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .RR_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .reserve_valid (reserve_valid),
    .reserve_reg   (reserve_reg),
    .write_enable  (write_enable),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .pending       (pending)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic [4:0] r2,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2,
                               input logic rv, input logic [4:0] rr);
    req_valid     = v;
    req_reg       = {r2, r1, r0};
    req_data      = {d2, d1, d0};
    reserve_valid = rv;
    reserve_reg   = rr;
  endtask

  task automatic idleInputs();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleOutputs();
    @(negedge clk);
  endtask

  task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  // Monitor: every write seen on the register file port must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && write_enable) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: actual reg=%0d data=%h required no write",
                 write_reg, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wb_reg", 32'(write_reg), 32'(mon_e.r));
        checkOutput("wb_data", write_data, mon_e.d);
      end
    end
  end

  initial begin
    int g;

    // Reset state, with all requesters valid to prove ready is gated.
    reset = 1'b1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, D0, D1, D2, 1'b1, 5'd4);
    nextCycle();
    nextCycle();
    sampleOutputs();
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_we", 32'(write_enable), 32'h0);
    checkOutput("reset_reg", 32'(write_reg), 32'h0);
    checkOutput("reset_data", write_data, 32'h0);
    checkOutput("reset_pending", pending, 32'h0);
    nextCycle();
    reset = 1'b0;

    // Single write from requester 1.
    applyStimulus(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0);
    sampleOutputs();
    checkOutput("single_ready", 32'(req_ready), 32'h2);
    expectWrite(5'd5, 32'hDEAD_BEEF);
    nextCycle();
    idleInputs();
    sampleOutputs();
    checkOutput("single_we_n1", 32'(write_enable), 32'h1);
    nextCycle();
    sampleOutputs();
    checkOutput("single_we_n2", 32'(write_enable), 32'h0);
    nextCycle();

    // Contention: all three requesters valid for six cycles.
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, D0, D1, D2, 1'b0, 5'd0);
      sampleOutputs();
`ifdef WB_ROUND_ROBIN_EN
      g = c % 3;
`else
      g = 0;
`endif
      checkOutput($sformatf("contention_grant_%0d", c), 32'(req_ready), 32'(1 << g));
      expectWrite(5'(g + 1), D0 + 32'(g));
      nextCycle();
    end
    idleInputs();
    sampleOutputs();
    nextCycle();

    // Scoreboard: reserve 7, write 7, pending clears two cycles after grant.
    doReset();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
    sampleOutputs();
    checkOutput("sb_pending_c0", pending, 32'h0);
    nextCycle();
    idleInputs();
    sampleOutputs();
    checkOutput("sb_pending_c1", pending, 32'h0000_0080);
    nextCycle();
    nextCycle();
    applyStimulus(3'b001, 5'd7, 5'd0, 5'd0, 32'h0000_0077, 32'h0, 32'h0, 1'b0, 5'd0);
    sampleOutputs();
    checkOutput("sb_ready_c3", 32'(req_ready), 32'h1);
    expectWrite(5'd7, 32'h0000_0077);
    nextCycle();
    idleInputs();
    sampleOutputs();
    checkOutput("sb_we_c4", 32'(write_enable), 32'h1);
    checkOutput("sb_pending_c4", pending, 32'h0000_0080);
    nextCycle();
    sampleOutputs();
    checkOutput("sb_pending_c5", pending, 32'h0);
    nextCycle();

    // Same register re-reserved on the commit edge: set wins.
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
    nextCycle();
    applyStimulus(3'b001, 5'd7, 5'd0, 5'd0, 32'h0000_0078, 32'h0, 32'h0, 1'b0, 5'd0);
    sampleOutputs();
    checkOutput("sb2_ready", 32'(req_ready), 32'h1);
    expectWrite(5'd7, 32'h0000_0078);
    nextCycle();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
    sampleOutputs();
    checkOutput("sb2_pending_wr", pending, 32'h0000_0080);
    nextCycle();
    idleInputs();
    sampleOutputs();
    checkOutput("sb2_set_wins", pending, 32'h0000_0080);
    nextCycle();

    // Register 0: accepted, no write, reservation ignored.
    doReset();
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    sampleOutputs();
    checkOutput("r0_ready", 32'(req_ready), 32'h4);
    nextCycle();
    idleInputs();
    sampleOutputs();
    checkOutput("r0_we", 32'(write_enable), 32'h0);
    checkOutput("r0_pending", pending, 32'h0);
    nextCycle();

    // Reset mid-operation: grant reg 9 in N, reset in N+1 and N+2.
    applyStimulus(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0000_0099, 32'h0, 1'b1, 5'd9);
    sampleOutputs();
    checkOutput("rst_grant_n", 32'(req_ready), 32'h2);
    nextCycle();
    reset = 1'b1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, D0, D1, D2, 1'b0, 5'd0);
    sampleOutputs();
    checkOutput("rst_ready_n1", 32'(req_ready), 32'h0);
    nextCycle();
    sampleOutputs();
    checkOutput("rst_we_n2", 32'(write_enable), 32'h0);
    checkOutput("rst_pending_n2", pending, 32'h0);
    checkOutput("rst_ready_n2", 32'(req_ready), 32'h0);
    nextCycle();
    reset = 1'b0;
    sampleOutputs();
    checkOutput("rst_first_grant", 32'(req_ready), 32'h1);
    expectWrite(5'd1, D0);
    nextCycle();
    idleInputs();
    sampleOutputs();
    checkOutput("rst_we_after", 32'(write_enable), 32'h1);
    nextCycle();

    // Idle: no writes, output address/data hold the last written values.
    for (int c = 0; c < 10; c++) begin
      sampleOutputs();
      checkOutput($sformatf("idle_we_%0d", c), 32'(write_enable), 32'h0);
      checkOutput($sformatf("idle_reg_%0d", c), 32'(write_reg), 32'd1);
      checkOutput($sformatf("idle_data_%0d", c), write_data, D0);
      nextCycle();
    end

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
